// File: rtl/i281_exec_pkg.sv
// Shared encodings for the i281 execution controller: FSM states and halt causes.
package i281_exec_pkg;

    localparam logic [1:0] ST_PAUSED = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    localparam logic [1:0] HC_NONE   = 2'd0;
    localparam logic [1:0] HC_STOP   = 2'd1;
    localparam logic [1:0] HC_BP     = 2'd2;
    localparam logic [1:0] HC_BUDGET = 2'd3;

endpackage

// File: rtl/i281_btn_pulse.sv
// Raw button to single-cycle pulse: multi-flop synchronizer followed by a rising-edge detector.
module i281_btn_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i281_exec_ctrl.sv
// i281 execution controller: turns board buttons, breakpoint and budget settings into the CPU run enable.
module i281_exec_ctrl
    import i281_exec_pkg::*;
#(
    parameter int PC_W        = 6,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_go,
    input  logic             btn_step,
    input  logic             btn_stop,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             budget_en,
    input  logic [CNT_W-1:0] budget,
    input  logic [PC_W-1:0]  current_pc,
    output logic             run,
    output logic             paused,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired_count
);

    logic go_pulse, step_pulse, stop_pulse;

    i281_btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_go (
        .clock(clock), .reset(reset), .async_in(btn_go), .pulse(go_pulse));
    i281_btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_step (
        .clock(clock), .reset(reset), .async_in(btn_step), .pulse(step_pulse));
    i281_btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_stop (
        .clock(clock), .reset(reset), .async_in(btn_stop), .pulse(stop_pulse));

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] remaining_q;
    logic             bp_skip_q;
    logic [1:0]       cause_q, cause_d;
    logic             cause_we, load_go;
    logic [CNT_W-1:0] retired_q;
    logic             bp_hit, budget_out;

    // bp_skip lets a resumed go execute the instruction sitting at the breakpoint once.
    assign bp_hit     = bp_en & (current_pc == bp_addr) & ~bp_skip_q;
    assign budget_out = budget_en & (remaining_q == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_PAUSED;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cause_we = 1'b0;
        cause_d  = HC_NONE;
        load_go  = 1'b0;
        case (state_q)
            ST_PAUSED: begin
                if (stop_pulse) begin
                    cause_we = 1'b1;
                    cause_d  = HC_STOP;
                end else if (go_pulse) begin
                    state_d  = ST_RUN;
                    load_go  = 1'b1;
                    cause_we = 1'b1;
                end else if (step_pulse) begin
                    state_d  = ST_STEP;
                    cause_we = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_pulse) begin
                    state_d  = ST_PAUSED;
                    cause_we = 1'b1;
                    cause_d  = HC_STOP;
                end else if (bp_hit) begin
                    state_d  = ST_PAUSED;
                    cause_we = 1'b1;
                    cause_d  = HC_BP;
                end else if (budget_out) begin
                    state_d  = ST_PAUSED;
                    cause_we = 1'b1;
                    cause_d  = HC_BUDGET;
                end
            end
            ST_STEP: state_d = ST_PAUSED;
            default: state_d = ST_PAUSED;
        endcase
    end

    always_comb begin
        run    = 1'b0;
        paused = 1'b0;
        case (state_q)
            ST_PAUSED: paused = 1'b1;
            ST_RUN:    run = ~stop_pulse & ~bp_hit & ~budget_out;
            ST_STEP:   run = 1'b1;
            default:   paused = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_q <= '0;
            bp_skip_q   <= 1'b0;
            cause_q     <= HC_NONE;
            retired_q   <= '0;
        end else begin
            if (load_go) begin
                remaining_q <= budget;
                bp_skip_q   <= 1'b1;
            end else if (state_q == ST_RUN && run) begin
                if (budget_en) remaining_q <= remaining_q - 1'b1;
                bp_skip_q <= 1'b0;
            end
            if (cause_we) cause_q <= cause_d;
            if (run && retired_q != '1) retired_q <= retired_q + 1'b1;
        end
    end

    assign halt_cause    = cause_q;
    assign retired_count = retired_q;

endmodule

// File: doc/i281_exec_ctrl.md
Name: i281_exec_ctrl

Overview:
- Execution controller that sequences the i281 CPU by generating the `run` enable consumed by the code memory, PC, flags, registers and data memory.
- Provides free-run, single-step, stop, PC breakpoint and instruction-budget halting from raw board buttons and switches.
- Sits between the board I/O and `i281_toplevel.run`, and observes the current PC.

Parameters:
- PC_W, 6, width of the program counter and breakpoint address.
- CNT_W, 16, width of the budget and retired-instruction counters.
- SYNC_STAGES, 2, synchronizer depth for the raw button inputs (must be at least 2).

Ports:
- clock  in  1  system clock, shared with the CPU.
- reset  in  1  asynchronous, active-low reset.
- btn_go  in  1  raw asynchronous button: start or resume free-run.
- btn_step  in  1  raw asynchronous button: execute exactly one instruction.
- btn_stop  in  1  raw asynchronous button: halt.
- bp_en  in  1  breakpoint enable (static switch).
- bp_addr  in  PC_W  breakpoint PC.
- budget_en  in  1  enable instruction budget.
- budget  in  CNT_W  instructions allowed per go; loaded on each accepted go.
- current_pc  in  PC_W  PC register output from the CPU.
- run  out  1  CPU advance enable; high means one instruction executes at the next clock edge.
- paused  out  1  high when the controller is in state PAUSED.
- halt_cause  out  2  cause of the last halt: 0 none, 1 stop, 2 breakpoint, 3 budget.
- retired_count  out  CNT_W  total cycles with run=1 since reset; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous) forces the following at once, including mid-run:
  - state PAUSED, run=0, halt_cause=0, retired_count=0, remaining=0, bp_skip=0.
  - All synchronizer and edge flops cleared.
- Each button passes through a SYNC_STAGES-flop synchronizer and a rising-edge detector.
  - Input first sampled high at edge k gives a one-cycle pulse in the cycle after edge k+SYNC_STAGES-1.
  - The FSM acts on that pulse at edge k+SYNC_STAGES.
  - A held button produces only one pulse.
- States: PAUSED, RUN, STEP. Encoding: PAUSED=0, RUN=1, STEP=2.
- Definitions:
  - bp_hit = bp_en & (current_pc == bp_addr) & ~bp_skip.
  - budget_out = budget_en & (remaining == 0).
- run is combinational from registered state and inputs:
  - STEP: run=1.
  - RUN: run = ~stop_pulse & ~bp_hit & ~budget_out.
  - PAUSED: run=0.
- PAUSED:
  - stop_pulse → stay PAUSED, halt_cause←1.
  - else go_pulse → RUN; remaining←budget; bp_skip←1; halt_cause←0.
  - else step_pulse → STEP; halt_cause←0.
  - If go and step pulse in the same cycle, go wins.
- RUN, conditions in priority order:
  - stop_pulse → PAUSED, halt_cause←1.
  - bp_hit → PAUSED, halt_cause←2; the instruction at bp_addr does not execute.
  - budget_out → PAUSED, halt_cause←3.
  - otherwise stay RUN; remaining decrements if budget_en; bp_skip←0.
  - go and step pulses are ignored in RUN.
- bp_skip behaviour:
  - It is cleared after the first run=1 cycle, so resuming from a breakpoint executes the breakpoint instruction once.
  - It must not re-trigger until the PC returns to bp_addr later.
- STEP:
  - Lasts exactly one cycle with run=1, then returns to PAUSED.
  - Ignores the breakpoint, the budget and all button pulses.
- budget=0 with budget_en=1: go enters RUN with run=0 and halts at the next edge with cause 3. Zero instructions retire.
- retired_count increments on every edge where run=1 and holds at 2^CNT_W−1.
- paused is registered state decode: high in PAUSED, low in RUN and STEP.

Decomposition:
- Package i281_exec_pkg holds:
  - state encoding constants ST_PAUSED, ST_RUN, ST_STEP.
  - halt cause constants HC_NONE, HC_STOP, HC_BP, HC_BUDGET.
- Sub-module i281_btn_pulse (parameter SYNC_STAGES):
  - Ports: clock, reset, async_in, pulse.
  - Instantiated three times, once per button.

Test Plan:
- Reset then btn_go held high 5 cycles, bp_en=0, budget_en=0 → go pulse at edge 2; run=1 from cycle 3 onward; exactly one pulse; paused=0; retired_count counts up each cycle.
- From PAUSED, btn_step high 10 cycles → run=1 for exactly one cycle; retired_count +1; back to PAUSED; halt_cause=0.
- bp_en=1, bp_addr=6'd5, go at pc=0, PC stepping by one:
  - run=0 when current_pc=5; PAUSED; halt_cause=2.
  - Second go → instruction at 5 executes; run continues through PC 6.
- budget_en=1, budget=3, go → exactly 3 run cycles; then PAUSED, halt_cause=3, retired_count=3. Repeat with budget=0 → 0 run cycles, halt_cause=3.
- In RUN, stop and breakpoint hit in the same cycle → run=0 that cycle; halt_cause=1 (stop wins).
- Assert reset mid-RUN → run drops without waiting for a clock edge. After release: PAUSED, halt_cause=0, retired_count=0.
